uart_tx_scheduler: RTL and testbench

- Shares the single UART transmitter between two requesters, e.g. the ALU result path and the register-file read path.
- Arbitrates between them, latches the winning 1- or 2-byte message, and feeds it byte by byte into the UART Tx.
- Sequences each byte with a one-cycle data-valid pulse and paces on the UART's Busy flag.
- Sits between the system controller and the UART Tx top.

---
 rtl/uart_tx_scheduler.sv | 105 ++++++++++
 tb/tb_uart_tx_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Arbitrates two requesters onto one UART Tx and sends 1- or 2-byte messages byte by byte.
// Define UART_TX_SCHED_RR_EN for round-robin ties; otherwise requester 0 wins every tie.
module uart_tx_scheduler #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    Reset,
  input  logic [1:0]              Req,
  input  logic [2*DATA_WIDTH-1:0] Req_data0,
  input  logic                    Req_len0,
  input  logic [2*DATA_WIDTH-1:0] Req_data1,
  input  logic                    Req_len1,
  input  logic                    Tx_busy,
  output logic [1:0]              Grant,
  output logic [DATA_WIDTH-1:0]   Tx_data,
  output logic                    Tx_valid,
  output logic                    Sched_busy
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_START, WAIT_DONE} state_t;

  state_t                  state_reg;
  logic [2*DATA_WIDTH-1:0] msg_reg;
  logic                    len_reg;
  logic                    idx_reg;
  logic                    winner_next;
  logic                    grant_fire;

  assign grant_fire = (state_reg == IDLE) && (Req != 2'b00) && !Tx_busy;

`ifdef UART_TX_SCHED_RR_EN
  logic ptr_reg;

  // ptr_reg names the requester preferred on a tie
  always_comb begin
    winner_next = ~Req[0];
    if (Req == 2'b11)
      winner_next = ptr_reg;
  end

  always_ff @(posedge CLK) begin
    if (!Reset)
      ptr_reg <= 1'b0;
    else if (grant_fire)
      ptr_reg <= ~winner_next;
  end
`else
  always_comb begin
    winner_next = ~Req[0];
  end
`endif

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_reg  <= IDLE;
      Grant      <= 2'b00;
      Tx_valid   <= 1'b0;
      Tx_data    <= '0;
      Sched_busy <= 1'b0;
      msg_reg    <= '0;
      len_reg    <= 1'b0;
      idx_reg    <= 1'b0;
    end else begin
      Grant    <= 2'b00;
      Tx_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_fire) begin
            msg_reg    <= winner_next ? Req_data1 : Req_data0;
            len_reg    <= winner_next ? Req_len1 : Req_len0;
            idx_reg    <= 1'b0;
            Grant      <= winner_next ? 2'b10 : 2'b01;
            Sched_busy <= 1'b1;
            state_reg  <= LOAD;
          end
        end
        LOAD: begin
          Tx_data   <= idx_reg ? msg_reg[2*DATA_WIDTH-1:DATA_WIDTH] : msg_reg[DATA_WIDTH-1:0];
          Tx_valid  <= 1'b1;
          state_reg <= WAIT_START;
        end
        WAIT_START: begin
          if (Tx_busy)
            state_reg <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!Tx_busy) begin
            if (len_reg && !idx_reg) begin
              idx_reg   <= 1'b1;
              state_reg <= LOAD;
            end else begin
              Sched_busy <= 1'b0;
              state_reg  <= IDLE;
            end
          end
        end
        default: begin
          Sched_busy <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: vector table, corner sequences, random messages vs model.
module tb_uart_tx_scheduler;

  logic        CLK;
  logic        Reset;
  logic [1:0]  Req;
  logic [15:0] Req_data0;
  logic        Req_len0;
  logic [15:0] Req_data1;
  logic        Req_len1;
  logic        Tx_busy;
  logic [1:0]  Grant;
  logic [7:0]  Tx_data;
  logic        Tx_valid;
  logic        Sched_busy;

  uart_tx_scheduler #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .Reset(Reset), .Req(Req),
    .Req_data0(Req_data0), .Req_len0(Req_len0),
    .Req_data1(Req_data1), .Req_len1(Req_len1),
    .Tx_busy(Tx_busy), .Grant(Grant), .Tx_data(Tx_data),
    .Tx_valid(Tx_valid), .Sched_busy(Sched_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit uart_auto = 1;
  int busy_len = 4;
  int busy_cnt = 0;
  int fall_cyc = 0;
  int grant_cyc = 0;
  bit await_first = 0;
  bit req_hold = 0;
  bit prev_sb = 0;
  bit prev_v = 0;
  int g_log[$];
  int b_log[$];

  typedef struct {
    logic [1:0]  req;
    logic [15:0] d0;
    logic        l0;
    logic [15:0] d1;
    logic        l1;
    int          blen;
    int          ng;
    int          g0;
    int          g1;
    int          nb;
    logic [31:0] bytes;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample outputs 1ns after the edge, then update requester and UART models.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (Grant != 2'b00) begin
      chk("grant_while_busy", int'(prev_sb), 0);
      chk("grant_onehot", $countones(Grant), 1);
      g_log.push_back(Grant[1] ? 1 : 0);
      grant_cyc   = cyc;
      await_first = 1;
      if (!req_hold) Req = Req & ~Grant;
    end
    if (Tx_valid) begin
      chk("valid_single_cycle", int'(prev_v), 0);
      b_log.push_back(int'(Tx_data));
      if (uart_auto) begin
        if (await_first) chk("byte0_latency", cyc, grant_cyc + 1);
        else             chk("byte1_latency", cyc, fall_cyc + 2);
        Tx_busy  = 1'b1;
        busy_cnt = busy_len;
      end
      await_first = 0;
    end else if (uart_auto && busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        Tx_busy  = 1'b0;
        fall_cyc = cyc;
      end
    end
    prev_sb = Sched_busy;
    prev_v  = Tx_valid;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    Req = 2'b00;
    Tx_busy = 1'b0;
    busy_cnt = 0;
    await_first = 0;
    step();
    step();
    Reset = 1'b1;
    g_log.delete();
    b_log.delete();
  endtask

  task automatic drain(input int budget);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < budget) begin
      step();
      n++;
      if (Req == 2'b00 && !Sched_busy && !Tx_busy) quiet++;
      else quiet = 0;
    end
    chk("drain_done", int'(quiet >= 3), 1);
  endtask

  task automatic check_logs(input string tag, input int eg[$], input int eb[$]);
    chk({tag, "_grant_count"}, g_log.size(), eg.size());
    chk({tag, "_byte_count"}, b_log.size(), eb.size());
    for (int i = 0; i < eg.size(); i++)
      if (i < g_log.size()) chk({tag, "_grant_id"}, g_log[i], eg[i]);
    for (int i = 0; i < eb.size(); i++)
      if (i < b_log.size()) chk({tag, "_byte"}, b_log[i], eb[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int eg[$];
    int eb[$];
    int ptr_m;
    int order[$];
    logic [15:0] dd;

    Reset = 1'b0; Req = 2'b00; Tx_busy = 1'b0;
    Req_data0 = 16'h0; Req_len0 = 1'b0; Req_data1 = 16'h0; Req_len1 = 1'b0;

    // Reset state while Reset is held low
    step();
    step();
    chk("reset_grant", int'(Grant), 0);
    chk("reset_valid", int'(Tx_valid), 0);
    chk("reset_data", int'(Tx_data), 0);
    chk("reset_sched_busy", int'(Sched_busy), 0);
    Reset = 1'b1;

    // Vector table; arbitration pointer starts at requester 0 after reset
    vecs[0] = '{2'b01, 16'hA55A, 1'b0, 16'h0000, 1'b0, 11, 1, 0, 0, 1, 32'h0000005A};
    vecs[1] = '{2'b10, 16'h0000, 1'b0, 16'h1234, 1'b1, 5,  1, 1, 0, 2, 32'h00001234};
    vecs[2] = '{2'b11, 16'hBEEF, 1'b1, 16'h00C3, 1'b0, 3,  2, 0, 1, 3, 32'h00C3BEEF};
    vecs[3] = '{2'b01, 16'h0077, 1'b0, 16'h0000, 1'b0, 1,  1, 0, 0, 1, 32'h00000077};
`ifdef UART_TX_SCHED_RR_EN
    vecs[4] = '{2'b11, 16'hCAFE, 1'b0, 16'hF00D, 1'b1, 2,  2, 1, 0, 3, 32'h00FEF00D};
`else
    vecs[4] = '{2'b11, 16'hCAFE, 1'b0, 16'hF00D, 1'b1, 2,  2, 0, 1, 3, 32'h00F00DFE};
`endif
    vecs[5] = '{2'b10, 16'h0000, 1'b0, 16'h8001, 1'b0, 20, 1, 1, 0, 1, 32'h00000001};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      g_log.delete(); b_log.delete(); eg.delete(); eb.delete();
      Req_data0 = vecs[i].d0; Req_len0 = vecs[i].l0;
      Req_data1 = vecs[i].d1; Req_len1 = vecs[i].l1;
      busy_len = vecs[i].blen;
      Req = vecs[i].req;
      drain(400);
      eg.push_back(vecs[i].g0);
      if (vecs[i].ng > 1) eg.push_back(vecs[i].g1);
      for (int k = 0; k < vecs[i].nb; k++) eb.push_back(int'(vecs[i].bytes[8*k +: 8]));
      check_logs("table", eg, eb);
      $display("vec %0d: req=%b grants=%0d bytes=%0d", i, vecs[i].req, g_log.size(), b_log.size());
    end

    // Reset while in WAIT_DONE drops the message
    do_reset();
    Req_data0 = 16'h6655; Req_len0 = 1'b1; busy_len = 20;
    Req = 2'b01;
    for (int n = 0; n < 50 && b_log.size() == 0; n++) step();
    chk("midreset_first_byte_seen", b_log.size(), 1);
    step(); step(); step();
    Reset = 1'b0;
    step();
    chk("midreset_valid", int'(Tx_valid), 0);
    chk("midreset_sched_busy", int'(Sched_busy), 0);
    chk("midreset_grant", int'(Grant), 0);
    chk("midreset_data", int'(Tx_data), 0);
    Reset = 1'b1; busy_cnt = 0; Tx_busy = 1'b0; Req = 2'b00;
    g_log.delete(); b_log.delete();
    for (int n = 0; n < 40; n++) step();
    chk("midreset_no_valid_after", b_log.size(), 0);
    chk("midreset_no_grant_after", g_log.size(), 0);
    $display("seq reset-mid-message done");

    // Busy gating: no grant while UART is still busy in IDLE
    do_reset();
    uart_auto = 1'b0;
    Tx_busy = 1'b1;
    Req_data0 = 16'h0099; Req_len0 = 1'b0;
    Req = 2'b01;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("gate_no_grant", int'(Grant), 0);
    end
    Tx_busy = 1'b0;
    step();
    chk("gate_release_grant", int'(Grant), 1);
    uart_auto = 1'b1; busy_len = 3;
    drain(200);
    eg = '{0}; eb = '{32'h99};
    check_logs("gate", eg, eb);
    $display("seq busy-gating done");

    // Request arriving during a message waits for IDLE
    do_reset();
    Req_data0 = 16'h4433; Req_len0 = 1'b1; busy_len = 6;
    Req = 2'b01;
    for (int n = 0; n < 50 && b_log.size() == 0; n++) step();
    step(); step(); step();
    Req_data1 = 16'h0055; Req_len1 = 1'b0;
    Req[1] = 1'b1;
    drain(300);
    eg = '{0, 1}; eb = '{32'h33, 32'h44, 32'h55};
    check_logs("during", eg, eb);
    $display("seq request-during-message done");

    // Tie held for three messages
    do_reset();
    Req_data0 = 16'h0101; Req_len0 = 1'b0;
    Req_data1 = 16'h0202; Req_len1 = 1'b0;
    busy_len = 2; req_hold = 1'b1;
    Req = 2'b11;
    for (int n = 0; n < 300 && g_log.size() < 3; n++) step();
    Req = 2'b00; req_hold = 1'b0;
    drain(200);
`ifdef UART_TX_SCHED_RR_EN
    eg = '{0, 1, 0}; eb = '{32'h01, 32'h02, 32'h01};
`else
    eg = '{0, 0, 0}; eb = '{32'h01, 32'h01, 32'h01};
`endif
    check_logs("tie", eg, eb);
    $display("seq tie-three-messages done");

    // Randomized messages against the reference model
    do_reset();
    ptr_m = 0;
    for (int t = 0; t < 30; t++) begin
      g_log.delete(); b_log.delete(); eg.delete(); eb.delete(); order.delete();
      Req_data0 = 16'($urandom); Req_len0 = 1'($urandom_range(0, 1));
      Req_data1 = 16'($urandom); Req_len1 = 1'($urandom_range(0, 1));
      busy_len = $urandom_range(1, 12);
      Req = 2'($urandom_range(1, 3));
      if (Req == 2'b11) begin
`ifdef UART_TX_SCHED_RR_EN
        order.push_back(ptr_m);
        order.push_back(1 - ptr_m);
`else
        order.push_back(0);
        order.push_back(1);
`endif
      end else begin
        order.push_back(Req[1] ? 1 : 0);
      end
      foreach (order[k]) begin
        eg.push_back(order[k]);
        ptr_m = 1 - order[k];
        dd = (order[k] == 1) ? Req_data1 : Req_data0;
        eb.push_back(int'(dd[7:0]));
        if ((order[k] == 1) ? Req_len1 : Req_len0) eb.push_back(int'(dd[15:8]));
      end
      drain(400);
      check_logs("random", eg, eb);
      $display("rand %0d: req=%b grants=%0d bytes=%0d busy_len=%0d", t, eg.size() == 2 ? 2'b11 : (eg[0] == 1 ? 2'b10 : 2'b01), g_log.size(), b_log.size(), busy_len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
